// File: rtl/uart_tx_scheduler_if.sv
// Requester/transmitter bundle for uart_tx_scheduler.
// The master modport is the scheduler side and the slave modport is the requester/transmitter side.
interface uart_tx_scheduler_if #(
  parameter int unsigned NREQ = 4
);
  logic [NREQ-1:0]   req;
  logic [NREQ*8-1:0] din;
  logic [NREQ-1:0]   grant;
  logic [NREQ-1:0]   ack;
  logic [8:0]        tx_frame;
  logic              tx_load;
  logic              tx_busy;
  logic              tx_err;
  logic              drop;

  modport master (
    input  req, din, tx_busy, tx_err,
    output grant, ack, tx_frame, tx_load, drop
  );

  modport slave (
    output req, din, tx_busy, tx_err,
    input  grant, ack, tx_frame, tx_load, drop
  );
endinterface

// File: rtl/uart_tx_scheduler.sv
// Round-robin scheduler sharing one UART transmitter among NREQ requesters.
// Optional retry-on-error path is enabled by defining UART_TX_SCHED_RETRY_EN.
module uart_tx_scheduler #(
  parameter int unsigned NREQ       = 4,
  parameter bit          PARITY_ODD = 1'b0,
  parameter int unsigned BUSY_TO    = 15,
  parameter int unsigned MAX_RETRY  = 2
) (
  input logic            clk,
  input logic            reset,
  uart_tx_scheduler_if.master bus
);

  localparam int unsigned IdxW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [2:0] {StIdle, StLoad, StWaitBusy, StWaitDone, StAck} state_e;

  state_e            state_q;
  logic [NREQ-1:0]   grant_q;
  logic [NREQ-1:0]   ack_q;
  logic [8:0]        frame_q;
  logic              tx_load_q;
  logic [IdxW-1:0]   rr_q;
  logic [IdxW-1:0]   g_q;
  logic [7:0]        to_cnt_q;

  logic              win_found;
  logic [IdxW-1:0]   win_idx;
  logic [IdxW-1:0]   cand;
  logic [7:0]        win_data;
  logic              win_par;
  logic [IdxW-1:0]   rr_next;

  // First set request at or after the rr pointer, wrapping modulo NREQ.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      cand = IdxW'((32'(rr_q) + i) % NREQ);
      if (!win_found && bus.req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  assign win_data = bus.din[{win_idx, 3'b000} +: 8];
  assign win_par  = PARITY_ODD ? ~^win_data : ^win_data;
  assign rr_next  = (g_q == IdxW'(NREQ - 1)) ? '0 : g_q + 1'b1;

`ifdef UART_TX_SCHED_RETRY_EN
  logic       err_q;
  logic [2:0] retry_q;
  logic       drop_q;
  logic       err_any;

  assign err_any  = err_q | bus.tx_err;
  assign bus.drop = drop_q;
`else
  logic       unused_err;
  logic [2:0] unused_max_retry;

  assign unused_err       = bus.tx_err;
  assign unused_max_retry = 3'(MAX_RETRY);
  assign bus.drop         = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= StIdle;
      grant_q   <= '0;
      ack_q     <= '0;
      frame_q   <= '0;
      tx_load_q <= 1'b0;
      rr_q      <= '0;
      g_q       <= '0;
      to_cnt_q  <= '0;
`ifdef UART_TX_SCHED_RETRY_EN
      err_q     <= 1'b0;
      retry_q   <= '0;
      drop_q    <= 1'b0;
`endif
    end else begin
      tx_load_q <= 1'b0;
      ack_q     <= '0;
`ifdef UART_TX_SCHED_RETRY_EN
      drop_q    <= 1'b0;
`endif
      unique case (state_q)
        StIdle: begin
          if (win_found) begin
            grant_q <= {{(NREQ-1){1'b0}}, 1'b1} << win_idx;
            g_q     <= win_idx;
            frame_q <= {win_par, win_data};
            state_q <= StLoad;
          end
        end
        StLoad: begin
          tx_load_q <= 1'b1;
          to_cnt_q  <= '0;
          state_q   <= StWaitBusy;
        end
        StWaitBusy: begin
`ifdef UART_TX_SCHED_RETRY_EN
          if (bus.tx_err) err_q <= 1'b1;
`endif
          if (bus.tx_busy) begin
            state_q <= StWaitDone;
          end else if (to_cnt_q == 8'(BUSY_TO - 1)) begin
            // Abandon silently; a still-high req is re-arbitrated from the next slot.
            state_q <= StIdle;
            grant_q <= '0;
            rr_q    <= rr_next;
`ifdef UART_TX_SCHED_RETRY_EN
            err_q   <= 1'b0;
            retry_q <= '0;
`endif
          end else begin
            to_cnt_q <= to_cnt_q + 8'd1;
          end
        end
        StWaitDone: begin
`ifdef UART_TX_SCHED_RETRY_EN
          if (!bus.tx_busy) begin
            if (err_any && (retry_q < 3'(MAX_RETRY))) begin
              err_q   <= 1'b0;
              retry_q <= retry_q + 3'd1;
              state_q <= StLoad;
            end else begin
              ack_q   <= grant_q;
              drop_q  <= err_any;
              state_q <= StAck;
            end
          end else if (bus.tx_err) begin
            err_q <= 1'b1;
          end
`else
          if (!bus.tx_busy) begin
            ack_q   <= grant_q;
            state_q <= StAck;
          end
`endif
        end
        StAck: begin
          grant_q <= '0;
          rr_q    <= rr_next;
          state_q <= StIdle;
`ifdef UART_TX_SCHED_RETRY_EN
          err_q   <= 1'b0;
          retry_q <= '0;
`endif
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.grant    = grant_q;
  assign bus.ack      = ack_q;
  assign bus.tx_frame = frame_q;
  assign bus.tx_load  = tx_load_q;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed, table-driven bench for uart_tx_scheduler plus hand sequences for timeout and reset.
module tb_uart_tx_scheduler;
  localparam int unsigned NREQ = 4;
`ifdef UART_TX_SCHED_RETRY_EN
  localparam int ErrLoads = 3;
  localparam bit ErrDrop  = 1'b1;
`else
  localparam int ErrLoads = 1;
  localparam bit ErrDrop  = 1'b0;
`endif

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  uart_tx_scheduler_if #(.NREQ(NREQ)) bus ();
  uart_tx_scheduler_if #(.NREQ(NREQ)) bus_odd ();

  uart_tx_scheduler #(
    .NREQ(NREQ), .PARITY_ODD(1'b0), .BUSY_TO(15), .MAX_RETRY(2)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus.master)
  );

  uart_tx_scheduler #(
    .NREQ(NREQ), .PARITY_ODD(1'b1), .BUSY_TO(15), .MAX_RETRY(2)
  ) dut_odd (
    .clk(clk), .reset(reset), .bus(bus_odd.master)
  );

  typedef struct {
    bit          do_reset;
    logic [3:0]  req;
    logic [31:0] din;
    int          busy_len;
    bit          err;
    logic [3:0]  exp_grant;
    logic [8:0]  exp_frame;
    int          exp_loads;
    bit          exp_drop;
  } vec_t;

  localparam logic [31:0] D = 32'h8007_0301;

  vec_t vecs[10];
  int   checks = 0;
  int   errors = 0;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    bus.req     = '0;
    bus.tx_busy = 1'b0;
    bus.tx_err  = 1'b0;
    reset       = 1'b0;
    tick();
    tick();
    reset = 1'b1;
  endtask

  task automatic run_frame(input int idx, input vec_t v);
    bit got;
    bit acked;
    int loads;
    if (v.do_reset) do_reset();
    bus.req = v.req;
    bus.din = v.din;
    got = 1'b0;
    for (int t = 0; t < 4 && !got; t++) begin
      tick();
      if (bus.grant != '0) got = 1'b1;
    end
    check($sformatf("v%0d_grant_seen", idx), 32'(got), 32'd1);
    if (!got) return;
    check($sformatf("v%0d_grant", idx), 32'(bus.grant), 32'(v.exp_grant));
    check($sformatf("v%0d_frame", idx), 32'(bus.tx_frame), 32'(v.exp_frame));
    check($sformatf("v%0d_load_early", idx), 32'(bus.tx_load), 32'd0);
    bus.din = ~v.din;  // din must be ignored after arbitration
    loads = 0;
    acked = 1'b0;
    for (int r = 0; r < 6 && !acked; r++) begin
      tick();
      if (bus.tx_load) loads++;
      bus.tx_busy = 1'b1;
      bus.tx_err  = v.err;
      tick();
      bus.tx_err = 1'b0;
      repeat (v.busy_len - 1) tick();
      bus.tx_busy = 1'b0;
      tick();
      if (bus.ack != '0) begin
        acked = 1'b1;
        check($sformatf("v%0d_ack", idx), 32'(bus.ack), 32'(v.exp_grant));
        check($sformatf("v%0d_drop", idx), 32'(bus.drop), 32'(v.exp_drop));
        check($sformatf("v%0d_frame_hold", idx), 32'(bus.tx_frame), 32'(v.exp_frame));
      end
    end
    check($sformatf("v%0d_acked", idx), 32'(acked), 32'd1);
    check($sformatf("v%0d_loads", idx), 32'(loads), 32'(v.exp_loads));
    tick();
    check($sformatf("v%0d_grant_clear", idx), 32'(bus.grant), 32'd0);
    check($sformatf("v%0d_ack_pulse", idx), 32'(bus.ack), 32'd0);
  endtask

  initial begin
    int  n;
    bit  ack_seen;

    vecs[0] = '{1'b1, 4'b0001, 32'h0000_00A5, 10, 1'b0, 4'b0001, 9'h0A5, 1, 1'b0};
    vecs[1] = '{1'b1, 4'b1111, D, 3, 1'b0, 4'b0001, 9'h101, 1, 1'b0};
    vecs[2] = '{1'b0, 4'b1111, D, 3, 1'b0, 4'b0010, 9'h003, 1, 1'b0};
    vecs[3] = '{1'b0, 4'b1111, D, 3, 1'b0, 4'b0100, 9'h107, 1, 1'b0};
    vecs[4] = '{1'b0, 4'b1111, D, 3, 1'b0, 4'b1000, 9'h180, 1, 1'b0};
    vecs[5] = '{1'b0, 4'b1111, D, 3, 1'b0, 4'b0001, 9'h101, 1, 1'b0};
    vecs[6] = '{1'b0, 4'b1111, D, 3, 1'b0, 4'b0010, 9'h003, 1, 1'b0};
    vecs[7] = '{1'b0, 4'b1111, D, 3, 1'b0, 4'b0100, 9'h107, 1, 1'b0};
    vecs[8] = '{1'b0, 4'b0101, D, 3, 1'b0, 4'b0001, 9'h101, 1, 1'b0};
    vecs[9] = '{1'b0, 4'b0001, D, 4, 1'b1, 4'b0001, 9'h101, ErrLoads, ErrDrop};

    bus.req         = '0;
    bus.din         = '0;
    bus.tx_busy     = 1'b0;
    bus.tx_err      = 1'b0;
    bus_odd.req     = 4'b0001;
    bus_odd.din     = '0;
    bus_odd.tx_busy = 1'b0;
    bus_odd.tx_err  = 1'b0;

    tick();
    check("rst_grant", 32'(bus.grant), 32'd0);
    check("rst_ack", 32'(bus.ack), 32'd0);
    check("rst_load", 32'(bus.tx_load), 32'd0);
    check("rst_frame", 32'(bus.tx_frame), 32'd0);
    check("rst_drop", 32'(bus.drop), 32'd0);
    reset = 1'b1;
    tick();
    check("odd_grant", 32'(bus_odd.grant), 32'd1);
    check("odd_frame", 32'(bus_odd.tx_frame), 32'h100);

    for (int i = 0; i < 10; i++) run_frame(i, vecs[i]);

    // Timeout: busy never rises, 15 cycles in WAIT_BUSY, then silent re-arbitration.
    bus.din = D;
    bus.req = 4'b0010;
    tick();
    check("to_grant", 32'(bus.grant), 32'b0010);
    tick();
    check("to_load", 32'(bus.tx_load), 32'd1);
    n        = 1;
    ack_seen = 1'b0;
    for (int t = 0; t < 40; t++) begin
      tick();
      if (bus.ack != '0) ack_seen = 1'b1;
      if (bus.grant == '0) break;
      n++;
    end
    check("to_cycles", 32'(n), 32'd15);
    check("to_no_ack", 32'(ack_seen), 32'd0);
    tick();
    check("to_regrant", 32'(bus.grant), 32'b0010);
    tick();
    check("to_reload", 32'(bus.tx_load), 32'd1);

    // Reset during WAIT_DONE clears outputs immediately.
    bus.tx_busy = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    #1;
    check("mid_rst_grant", 32'(bus.grant), 32'd0);
    check("mid_rst_ack", 32'(bus.ack), 32'd0);
    check("mid_rst_load", 32'(bus.tx_load), 32'd0);
    check("mid_rst_frame", 32'(bus.tx_frame), 32'd0);
    bus.req     = 4'b1111;
    bus.tx_busy = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    check("post_rst_grant", 32'(bus.grant), 32'b0001);
    check("post_rst_ack", 32'(bus.ack), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
